// File: rtl/arb4_sel.sv
// arb4_sel: 4-channel round-robin select for a downstream Mux4Way16; grant one cycle after req.
// out_ready low holds the grant (no re-arbitration); ARB4_LOCK_EN adds the lock port for burst hold.
module arb4_sel (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       out_ready,
`ifdef ARB4_LOCK_EN
  input  logic       lock,
`endif
  output logic [1:0] sel,
  output logic       out_valid,
  output logic [3:0] ack,
  output logic       busy
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] sel_oh;
  logic [3:0] rem_req;
  logic       xfer;
  logic       hold_burst;

  // First set bit of m searching base+1, base+2, base+3, base+4 (mod 4).
  function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [3:0] m);
    logic [1:0] idx;
    rr_pick = base;
    for (int i = 4; i >= 1; i--) begin
      idx = base + 2'(i);
      if (m[idx]) rr_pick = idx;
    end
  endfunction

`ifdef ARB4_LOCK_EN
  assign hold_burst = lock;
`else
  assign hold_burst = 1'b0;
`endif

  assign sel_oh  = 4'b0001 << sel_q;
  assign xfer    = (state_q == GRANT) && out_ready;
  assign rem_req = req & ~sel_oh;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          state_d = GRANT;
          sel_d   = rr_pick(ptr_q, req);
        end
      end
      GRANT: begin
        if (xfer) begin
          if (!hold_burst) begin
            ptr_d = sel_q;
            if (rem_req != 4'b0000) sel_d = rr_pick(sel_q, rem_req);
            else                    state_d = IDLE;
          end
        end else if (!req[sel_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 2'b00;
      ptr_q   <= 2'b11;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  // A grant being torn down by reset never acknowledges.
  assign ack       = (xfer && !reset) ? sel_oh : 4'b0000;
  assign sel       = sel_q;
  assign out_valid = (state_q == GRANT);
  assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_arb4_sel.sv
// Table-driven bench for arb4_sel; each row gives one cycle's inputs and that cycle's expected outputs.
module tb_arb4_sel;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       out_ready;
  logic       lock;
  logic [1:0] sel;
  logic       out_valid;
  logic [3:0] ack;
  logic       busy;

  always #5 clk = ~clk;

  arb4_sel dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .out_ready (out_ready),
`ifdef ARB4_LOCK_EN
    .lock      (lock),
`endif
    .sel       (sel),
    .out_valid (out_valid),
    .ack       (ack),
    .busy      (busy)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic       lk;
    logic       chk;
    logic       v;
    logic [1:0] s;
    logic [3:0] a;
  } vec_t;

  typedef struct {
    int         row;
    logic       v;
    logic [1:0] s;
    logic [3:0] a;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic rst, input logic [3:0] r, input logic rdy, input logic lk,
                     input logic chk, input logic v, input logic [1:0] s, input logic [3:0] a);
    vec_t t;
    t.rst = rst; t.req = r; t.rdy = rdy; t.lk = lk;
    t.chk = chk; t.v = v; t.s = s; t.a = a;
    vecs.push_back(t);
  endtask

  task automatic check_bits(input string name, input int row, input logic [3:0] act, input logic [3:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s row %0d: got %b, expected %b", name, row, act, want);
    end
  endtask

  initial begin
    exp_t e;
    vec_t t;
    reset = 1'b1; req = 4'b0; out_ready = 1'b0; lock = 1'b0;

    // reset state, then single request on channel 2
    add(1, 4'b0000, 0, 0, 0, 0, 2'd0, 4'b0000);
    add(0, 4'b0000, 0, 0, 1, 0, 2'd0, 4'b0000);
    add(0, 4'b0100, 1, 0, 1, 0, 2'd0, 4'b0000);
    add(0, 4'b0100, 1, 0, 1, 1, 2'd2, 4'b0100);
    add(0, 4'b0000, 1, 0, 1, 0, 2'd0, 4'b0000);
    // all four requesting after reset: 0,1,2,3,0 with no bubble
    add(1, 4'b1111, 1, 0, 1, 0, 2'd0, 4'b0000);
    add(0, 4'b1111, 1, 0, 1, 0, 2'd0, 4'b0000);
    add(0, 4'b1111, 1, 0, 1, 1, 2'd0, 4'b0001);
    add(0, 4'b1111, 1, 0, 1, 1, 2'd1, 4'b0010);
    add(0, 4'b1111, 1, 0, 1, 1, 2'd2, 4'b0100);
    add(0, 4'b1111, 1, 0, 1, 1, 2'd3, 4'b1000);
    add(0, 4'b1111, 1, 0, 1, 1, 2'd0, 4'b0001);
    add(1, 4'b0000, 0, 0, 1, 1, 2'd1, 4'b0000);
    // backpressure: sel=0 held five stalled cycles, one ack, then channel 1
    add(0, 4'b0011, 0, 0, 1, 0, 2'd0, 4'b0000);
    for (int i = 0; i < 5; i++) add(0, 4'b0011, 0, 0, 1, 1, 2'd0, 4'b0000);
    add(0, 4'b0011, 1, 0, 1, 1, 2'd0, 4'b0001);
    add(0, 4'b0010, 1, 0, 1, 1, 2'd1, 4'b0010);
    add(0, 4'b0000, 0, 0, 1, 0, 2'd0, 4'b0000);
    // channel 2 withdraws before transfer; pointer stays on 1
    add(0, 4'b0100, 0, 0, 1, 0, 2'd0, 4'b0000);
    add(0, 4'b0000, 0, 0, 1, 1, 2'd2, 4'b0000);
    add(0, 4'b1001, 0, 0, 1, 0, 2'd0, 4'b0000);
    add(0, 4'b1001, 1, 0, 1, 1, 2'd3, 4'b1000);
    add(0, 4'b0001, 0, 0, 1, 1, 2'd0, 4'b0000);
    add(0, 4'b0001, 1, 0, 1, 1, 2'd0, 4'b0001);
    // reset while granted on channel 3, then lowest requester wins
    add(0, 4'b1000, 0, 0, 1, 0, 2'd0, 4'b0000);
    add(1, 4'b1000, 0, 0, 1, 1, 2'd3, 4'b0000);
    add(0, 4'b1010, 1, 0, 1, 0, 2'd0, 4'b0000);
    add(0, 4'b1010, 1, 0, 1, 1, 2'd1, 4'b0010);
    add(0, 4'b1000, 1, 0, 1, 1, 2'd3, 4'b1000);
    add(0, 4'b0000, 0, 0, 1, 0, 2'd0, 4'b0000);
`ifdef ARB4_LOCK_EN
    // burst lock keeps channel 0 for three words, releases on the fourth
    add(1, 4'b0000, 0, 0, 1, 0, 2'd0, 4'b0000);
    add(0, 4'b0011, 0, 0, 1, 0, 2'd0, 4'b0000);
    for (int i = 0; i < 3; i++) add(0, 4'b0011, 1, 1, 1, 1, 2'd0, 4'b0001);
    add(0, 4'b0011, 1, 0, 1, 1, 2'd0, 4'b0001);
    add(0, 4'b0010, 1, 0, 1, 1, 2'd1, 4'b0010);
    add(0, 4'b0000, 0, 0, 1, 0, 2'd0, 4'b0000);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      t = vecs[i];
      reset = t.rst; req = t.req; out_ready = t.rdy; lock = t.lk;
      if (t.chk) begin
        e.row = i; e.v = t.v; e.s = t.s; e.a = t.a;
        exp_q.push_back(e);
      end
      #1;
      if (t.chk) begin
        e = exp_q.pop_front();
        check_bits("out_valid", e.row, {3'b0, out_valid}, {3'b0, e.v});
        check_bits("busy", e.row, {3'b0, busy}, {3'b0, e.v});
        check_bits("ack", e.row, ack, e.a);
        check_bits("ack_onehot0", e.row, {3'b0, $onehot0(ack)}, 4'b0001);
        if (e.v) check_bits("sel", e.row, {2'b0, sel}, {2'b0, e.s});
      end
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb4_sel.md
ARB4_SEL -- requirements
Module: arb4_sel

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk only.
REQ-002 Port clk  input  1  system clock.
REQ-003 Port reset  input  1  synchronous active-high reset.
REQ-004 Port req  input  4  per-channel request; req[n] held high by channel n until it sees ack[n].
REQ-005 Port out_ready  input  1  downstream consumer accepts the selected word this cycle.
REQ-006 Port lock  input  1  burst hold for the granted channel; present only with ARB4_LOCK_EN.
REQ-007 Port sel  output  2  select code driving the sel input of the downstream Mux4Way16 (channel n on i<n>).
REQ-008 Port out_valid  output  1  selected word on the Mux4Way16 output is valid.
REQ-009 Port ack  output  4  one-hot transfer acknowledge to the granted channel.
REQ-010 Port busy  output  1  high in state GRANT.

Function
REQ-011 The block SHALL implement two states: IDLE (out_valid=0) and GRANT (out_valid=1); busy SHALL equal (state==GRANT).
REQ-012 A 2-bit pointer ptr SHALL hold the last transferred channel; the search order SHALL be ptr+1, ptr+2, ptr+3, ptr+4 (mod 4).
REQ-013 IDLE: if req!=0, the next state SHALL be GRANT with sel = first requesting channel in search order; if req==0, remain IDLE and keep sel unchanged.
REQ-014 Grant latency SHALL be exactly one cycle: req asserted in cycle t with the block IDLE gives out_valid=1 in cycle t+1.
REQ-015 A transfer SHALL occur in a cycle where out_valid=1 and out_ready=1; sel SHALL be stable from grant until the transfer cycle inclusive.
REQ-016 ack SHALL be combinational: ack = onehot(sel) when out_valid&out_ready, else 4'b0000; at most one bit SHALL be high.
REQ-017 At a transfer (no lock): ptr<=sel; the search SHALL use req & ~onehot(sel); if nonzero, remain GRANT with new sel (back-to-back, no bubble), else go IDLE.
REQ-018 GRANT with out_ready=0: state, sel and ptr SHALL hold; no re-arbitration while waiting.
REQ-019 GRANT with req[sel]=0 and no transfer (channel withdrew): next state SHALL be IDLE, ptr unchanged, no ack.
REQ-020 A simultaneous transfer and withdrawal cannot occur; transfer (REQ-017) SHALL take priority in evaluation.
REQ-021 Pointer wrap: ptr=3 SHALL search 0,1,2,3; all four channels requesting continuously SHALL be served 0,1,2,3,0,... with one grant per transfer.
REQ-022 Requests arriving for non-granted channels during GRANT SHALL be latched by the requester (req held) and served in round-robin order; none SHALL be lost.

Reset
REQ-023 With reset=1 at a clock edge: state<=IDLE, sel<=2'b00, ptr<=2'b11, so out_valid=0, busy=0, ack=0 in the following cycle.
REQ-024 Reset asserted mid-GRANT SHALL abandon the grant with no ack; the first post-reset grant SHALL go to the lowest-numbered requesting channel.

Configuration
REQ-025 Macro ARB4_LOCK_EN SHALL compile in the lock port and burst-hold behaviour.
REQ-026 With ARB4_LOCK_EN defined: at a transfer with lock=1, state SHALL stay GRANT, sel and ptr SHALL be unchanged, and the same channel SHALL keep ownership for the next word regardless of other requests; lock=0 at a transfer SHALL follow REQ-017.
REQ-027 Without ARB4_LOCK_EN: the lock port SHALL not exist and behaviour SHALL be exactly REQ-011..REQ-024.

Verification
REQ-028 Reset, then req=4'b0100, out_ready=1 -> cycle+1: out_valid=1, sel=2, ack=4'b0100; next cycle out_valid=0 after req drops.
REQ-029 req=4'b1111 held, out_ready=1 continuously after reset -> sel sequence 0,1,2,3,0 on consecutive cycles, one-hot ack each cycle, no bubble.
REQ-030 req=4'b0011, out_ready=0 for 5 cycles then 1 -> sel=0 stable for all 6 cycles, single ack=4'b0001, then sel=1 next cycle.
REQ-031 Granted on channel 2, req[2] dropped before out_ready -> out_valid=0 next cycle, no ack, ptr still selects channel 3 first when req=4'b1000|4'b0001 later (sel=3).
REQ-032 Reset pulsed while GRANT on channel 3 -> out_valid=0, ack=0 next cycle; req=4'b1010 afterwards -> sel=1.
REQ-033 (ARB4_LOCK_EN) req=4'b0011, lock=1 for 3 transfers -> sel=0 for 3 acks; lock=0 on the 4th transfer -> next sel=1.
